// File: rtl/pc_next_unit.sv
// pc_next_unit: holds the PC, selects next PC (pc+4/branch/jal/jalr), sequences fetch, counts retires.
// Latency: 2 cycles per instruction (FETCH + EXEC) plus one cycle per low imem_ready in FETCH.
// Backpressure: imem_ready low holds FETCH; stall high holds EXEC with pc/instret frozen.
// Build option: define PC_MISALIGN_TRAP_EN to send redirects with target[1]=1 to TRAP_PC.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_taken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  input  logic        stall,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {BOOT, FETCH, EXEC} state_t;

  state_t      state, state_nxt;
  logic        retire;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] next_pc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // next state and fetch handshake; retire only on an unstalled EXEC cycle
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nxt = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!stall) begin
          retire    = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // redirect target: jalr beats jal and branch, which share pc+imm
  always_comb begin
    redirect = jalr | jal | br_taken;
    if (jalr) target = (rs1 + imm) & ~32'h1;
    else      target = pc + imm;
  end

`ifdef PC_MISALIGN_TRAP_EN
  // a redirect to a half-word address goes to the trap vector; the instruction still retires
  always_comb begin
    misalign = retire & redirect & target[1];
    if (!redirect)      next_pc = pc_plus4;
    else if (target[1]) next_pc = TRAP_PC;
    else                next_pc = target;
  end
`else
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
  assign misalign       = 1'b0;

  // redirect targets are word-aligned by dropping the low two bits
  always_comb begin
    next_pc = redirect ? (target & ~32'h3) : pc_plus4;
  end
`endif

  // pc and retired-instruction counter advance together on retire
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instret <= '0;
    end else if (retire) begin
      pc      <= next_pc;
      instret <= instret + 64'd1;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
`timescale 1ns/1ps
module tb_pc_next_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0100;

  logic        clk, rst_n, br_taken, jal, jalr, stall, imem_ready;
  logic [31:0] imm, rs1;
  logic        imem_req, instr_valid, misalign;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [63:0] instret;

  pc_next_unit #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk(clk), .rst_n(rst_n), .br_taken(br_taken), .jal(jal), .jalr(jalr),
    .imm(imm), .rs1(rs1), .stall(stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4), .misalign(misalign), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;       // next pc, default build
    logic [31:0] exp_pc_trap;  // next pc, trap build
    logic        exp_mis_trap; // misalign, trap build
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [63:0] instret;
  } sb_t;

  vec_t        vecs[15];
  sb_t         sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc;
  logic [63:0] cur_ret;

  function automatic vec_t mk(input logic b, input logic j, input logic jr,
                              input logic [31:0] im, input logic [31:0] r1,
                              input logic [31:0] ep, input logic [31:0] ept,
                              input logic em);
    vec_t v;
    v.br = b; v.jal = j; v.jalr = jr; v.imm = im; v.rs1 = r1;
    v.exp_pc = ep; v.exp_pc_trap = ept; v.exp_mis_trap = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl();
    br_taken = 1'b0; jal = 1'b0; jalr = 1'b0; imm = '0; rs1 = '0;
  endtask

  // bounded wait for FETCH; an expired budget shows up as a failed check
  task automatic wait_fetch();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_timeout", {63'd0, imem_req}, 64'd1);
  endtask

  // one instruction: FETCH -> EXEC (drive controls) -> next FETCH (compare)
  task automatic exec_vec(input vec_t v);
    sb_t         e;
    logic [31:0] p4;
    wait_fetch();
    check("fetch_addr", {32'd0, imem_addr}, {32'd0, cur_pc});
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    p4 = cur_pc + 32'd4;
    check("exec_valid", {63'd0, instr_valid}, 64'd1);
    check("exec_req", {63'd0, imem_req}, 64'd0);
    check("exec_pc", {32'd0, pc}, {32'd0, cur_pc});
    check("pc_plus4", {32'd0, pc_plus4}, {32'd0, p4});
    br_taken = v.br; jal = v.jal; jalr = v.jalr; imm = v.imm; rs1 = v.rs1; stall = 1'b0;
    #1;
`ifdef PC_MISALIGN_TRAP_EN
    e.pc = v.exp_pc_trap;
    check("misalign", {63'd0, misalign}, {63'd0, v.exp_mis_trap});
`else
    e.pc = v.exp_pc;
    check("misalign", {63'd0, misalign}, 64'd0);
`endif
    e.instret = cur_ret + 64'd1;
    sb_q.push_back(e);
    @(negedge clk);
    clear_ctrl();
    e = sb_q.pop_front();
    check("next_pc", {32'd0, pc}, {32'd0, e.pc});
    check("instret", instret, e.instret);
    check("refetch_req", {63'd0, imem_req}, 64'd1);
    check("fetch_misalign", {63'd0, misalign}, 64'd0);
    cur_pc  = e.pc;
    cur_ret = e.instret;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sb_t e;
    rst_n = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    clear_ctrl();

    vecs[0]  = mk(0, 0, 0, 32'h0,        32'h0,        32'h4,        32'h4,        0);
    vecs[1]  = mk(0, 0, 0, 32'h0,        32'h0,        32'h8,        32'h8,        0);
    vecs[2]  = mk(0, 0, 0, 32'h0,        32'h0,        32'hC,        32'hC,        0);
    vecs[3]  = mk(0, 0, 1, 32'h0,        32'h40,       32'h40,       32'h40,       0);
    vecs[4]  = mk(1, 0, 0, 32'hFFFF_FFF0, 32'h0,       32'h30,       32'h30,       0);
    vecs[5]  = mk(0, 0, 1, 32'h0,        32'h40,       32'h40,       32'h40,       0);
    vecs[6]  = mk(0, 0, 0, 32'hFFFF_FFF0, 32'h0,       32'h44,       32'h44,       0);
    vecs[7]  = mk(0, 1, 1, 32'h4,        32'h1001,     32'h1004,     32'h1004,     0);
    vecs[8]  = mk(0, 1, 0, 32'hC,        32'h0,        32'h1010,     32'h1010,     0);
    vecs[9]  = mk(0, 0, 1, 32'h8,        32'h8,        32'h10,       32'h10,       0);
    vecs[10] = mk(0, 1, 0, 32'h6,        32'h0,        32'h14,       TRP_PC,       1);
    vecs[11] = mk(0, 0, 1, 32'hC,        32'hFFFF_FFF0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0);
    vecs[12] = mk(0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0);
    vecs[13] = mk(1, 0, 0, 32'h20,       32'h0,        32'h20,       32'h20,       0);
    vecs[14] = mk(0, 0, 1, 32'h1,        32'h202,      32'h200,      TRP_PC,       1);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_pc", {32'd0, pc}, {32'd0, RST_PC});
    check("rst_instret", instret, 64'd0);
    check("rst_req", {63'd0, imem_req}, 64'd0);
    check("rst_valid", {63'd0, instr_valid}, 64'd0);
    check("rst_misalign", {63'd0, misalign}, 64'd0);

    // BOOT idles one cycle even with imem_ready high
    rst_n = 1'b1;
    cur_pc = RST_PC; cur_ret = '0;
    #1;
    check("boot_req", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    check("boot_to_fetch", {63'd0, imem_req}, 64'd1);
    check("boot_no_exec", {63'd0, instr_valid}, 64'd0);
    imem_ready = 1'b0;

    for (int i = 0; i < 15; i++) exec_vec(vecs[i]);

    // imem_ready low for 3 FETCH cycles: wait in FETCH, nothing moves
    wait_fetch();
    repeat (3) begin
      @(negedge clk);
      check("wait_req", {63'd0, imem_req}, 64'd1);
      check("wait_valid", {63'd0, instr_valid}, 64'd0);
      check("wait_pc", {32'd0, pc}, {32'd0, cur_pc});
      check("wait_instret", instret, cur_ret);
    end
    // two stalled EXEC cycles with live-looking controls and imem_ready, all ignored
    stall = 1'b1; jal = 1'b1; imm = 32'h40; imem_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stall_valid", {63'd0, instr_valid}, 64'd1);
      check("stall_req", {63'd0, imem_req}, 64'd0);
      check("stall_pc", {32'd0, pc}, {32'd0, cur_pc});
      check("stall_instret", instret, cur_ret);
      check("stall_misalign", {63'd0, misalign}, 64'd0);
    end
    stall = 1'b0; imem_ready = 1'b0;
    clear_ctrl();
    e.pc = cur_pc + 32'd4;
    e.instret = cur_ret + 64'd1;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    check("unstall_pc", {32'd0, pc}, {32'd0, e.pc});
    check("unstall_instret", instret, e.instret);
    cur_pc = e.pc; cur_ret = e.instret;

    // reset in a stalled EXEC aborts immediately without retiring
    wait_fetch();
    stall = 1'b1; imem_ready = 1'b1;
    @(negedge clk);
    check("pre_abort_valid", {63'd0, instr_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_pc", {32'd0, pc}, {32'd0, RST_PC});
    check("abort_instret", instret, 64'd0);
    check("abort_valid", {63'd0, instr_valid}, 64'd0);
    check("abort_req", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;
    cur_pc = RST_PC; cur_ret = '0;
    #1;
    check("reboot_req", {63'd0, imem_req}, 64'd0);
    @(negedge clk);
    imem_ready = 1'b0;
    check("reboot_fetch", {63'd0, imem_req}, 64'd1);
    exec_vec(vecs[0]);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
